// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use detection and stall/flush.
// Latency: ID fields appear on the EX outputs 1 cycle after capture; forwarding and load_use are combinational.
// Backpressure: stall holds EX (refreshing held operands from the forward muxes); flush or load_use loads a bubble.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   id_*                 decoded instruction from ID (operands, indices, immediate, ALU and memory control)
//   stall, flush         hazard/branch control: hold EX, or squash EX
//   mem_*, wb_*          forwarding sources from the MEM and WB stages
//   alu_a, alu_b, alu_f  ALU operands and function
//   ex_*                 EX-stage valid, destination, control and forwarded store data
//   load_use             request to freeze IF/ID for one cycle
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs_val,
    input  logic [XLEN-1:0] id_rt_val,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic [RW-1:0]   id_rd,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alusrc,
    input  logic [2:0]      id_aluctrl,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_regwrite,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_regwrite,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_f,
    output logic            ex_valid,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use
);

    logic            valid_q;
    logic [RW-1:0]   rs_q, rt_q, rd_q;
    logic [XLEN-1:0] rs_val_q, rt_val_q, imm_q;
    logic            alusrc_q;
    logic [2:0]      aluctrl_q;
    logic            regwrite_q, memread_q, memwrite_q, memtoreg_q;

    logic [XLEN-1:0] fwd_a, fwd_b;
    logic            mem_fwd_ok, wb_fwd_ok;

    // Register 0 is hard-wired zero, so a write to it is never a forward source.
    assign mem_fwd_ok = mem_regwrite && (mem_rd != '0);
    assign wb_fwd_ok  = wb_regwrite  && (wb_rd  != '0);

    // MEM holds the younger result, so it takes precedence over WB.
    always_comb begin
        fwd_a = rs_val_q;
        if (mem_fwd_ok && (mem_rd == rs_q)) begin
            fwd_a = mem_result;
        end else if (wb_fwd_ok && (wb_rd == rs_q)) begin
            fwd_a = wb_result;
        end
    end

    always_comb begin
        fwd_b = rt_val_q;
        if (mem_fwd_ok && (mem_rd == rt_q)) begin
            fwd_b = mem_result;
        end else if (wb_fwd_ok && (wb_rd == rt_q)) begin
            fwd_b = wb_result;
        end
    end

    assign alu_a         = fwd_a;
    assign ex_store_data = fwd_b;
    assign alu_b         = alusrc_q ? imm_q : fwd_b;
    assign alu_f         = aluctrl_q;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_memwrite   = memwrite_q;
    assign ex_memtoreg   = memtoreg_q;

    assign load_use = valid_q && memread_q && (rd_q != '0) && id_valid &&
                      ((rd_q == id_rs) || (rd_q == id_rt));

    always_ff @(posedge clk) begin
        // Reset, flush and an unstalled load-use all leave EX as an all-zero bubble;
        // flush outranks stall, stall outranks load-use.
        if (rst || flush || (!stall && load_use)) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else if (stall) begin
            // Latch the forwarded operands so they survive the producer retiring while we wait.
            rs_val_q <= fwd_a;
            rt_val_q <= fwd_b;
        end else begin
            valid_q    <= id_valid;
            rs_q       <= id_rs;
            rt_q       <= id_rt;
            rd_q       <= id_rd;
            rs_val_q   <= id_rs_val;
            rt_val_q   <= id_rt_val;
            imm_q      <= id_imm;
            alusrc_q   <= id_alusrc;
            aluctrl_q  <= id_aluctrl;
            regwrite_q <= id_valid && id_regwrite;
            memread_q  <= id_valid && id_memread;
            memwrite_q <= id_valid && id_memwrite;
            memtoreg_q <= id_valid && id_memtoreg;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    typedef struct {
        logic        rst, valid, stall, flush;
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  rs, rt, rd;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic        regwrite, memread, memwrite, memtoreg;
        logic        mem_regwrite, wb_regwrite;
        logic [4:0]  mem_rd, wb_rd;
        logic [31:0] mem_result, wb_result;
    } stim_t;

    // Architectural content of the EX slot as the reference model sees it.
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_val, rt_val, imm;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic        rw, mr, mw, mt;
    } slot_t;

    typedef struct {
        logic [31:0] a, b, st;
        logic [2:0]  f;
        logic        v, lu, rw, mr, mw, mt;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, id_valid, stall, flush;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_alusrc;
    logic [2:0]  id_aluctrl;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_f;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use;
    logic [4:0]  ex_rd;

    id_ex_stage #(.XLEN(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluctrl(id_aluctrl),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .stall(stall), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_store_data(ex_store_data), .load_use(load_use)
    );

    always #5 clk = ~clk;

    int    n_pass  = 0;
    int    n_total = 0;
    exp_t  sb_q[$];
    slot_t model;
    bit    done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Value an operand takes in EX: the younger non-zero writer wins, else the held value.
    function automatic logic [31:0] operand(logic [4:0] idx, logic [31:0] held, stim_t s);
        if (s.mem_regwrite && s.mem_rd != 0 && s.mem_rd == idx) return s.mem_result;
        if (s.wb_regwrite && s.wb_rd != 0 && s.wb_rd == idx) return s.wb_result;
        return held;
    endfunction

    function automatic logic hazard(slot_t m, stim_t s);
        return m.valid && m.mr && m.rd != 0 && s.valid && (m.rd == s.rs || m.rd == s.rt);
    endfunction

    function automatic exp_t predict(slot_t m, stim_t s);
        exp_t e;
        e.a  = operand(m.rs, m.rs_val, s);
        e.st = operand(m.rt, m.rt_val, s);
        e.b  = m.alusrc ? m.imm : e.st;
        e.f  = m.aluctrl;
        e.v  = m.valid;
        e.rd = m.rd;
        e.rw = m.rw; e.mr = m.mr; e.mw = m.mw; e.mt = m.mt;
        e.lu = hazard(m, s);
        return e;
    endfunction

    function automatic slot_t advance(slot_t m, stim_t s);
        slot_t n;
        n = '{default: '0};
        if (s.rst || s.flush) return n;
        if (s.stall) begin
            n = m;
            n.rs_val = operand(m.rs, m.rs_val, s);
            n.rt_val = operand(m.rt, m.rt_val, s);
            return n;
        end
        if (hazard(m, s)) return n;
        n.valid = s.valid;
        n.rs = s.rs; n.rt = s.rt; n.rd = s.rd;
        n.rs_val = s.rs_val; n.rt_val = s.rt_val; n.imm = s.imm;
        n.alusrc = s.alusrc; n.aluctrl = s.aluctrl;
        n.rw = s.valid & s.regwrite; n.mr = s.valid & s.memread;
        n.mw = s.valid & s.memwrite; n.mt = s.valid & s.memtoreg;
        return n;
    endfunction

    // Drive one cycle of stimulus shortly after the rising edge, queue the expected
    // response for the monitor, then step the model across the next edge.
    task automatic cycle(input stim_t s, input bit expect_out);
        rst = s.rst; id_valid = s.valid; stall = s.stall; flush = s.flush;
        id_rs_val = s.rs_val; id_rt_val = s.rt_val; id_imm = s.imm;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
        id_alusrc = s.alusrc; id_aluctrl = s.aluctrl;
        id_regwrite = s.regwrite; id_memread = s.memread;
        id_memwrite = s.memwrite; id_memtoreg = s.memtoreg;
        mem_regwrite = s.mem_regwrite; mem_rd = s.mem_rd; mem_result = s.mem_result;
        wb_regwrite = s.wb_regwrite; wb_rd = s.wb_rd; wb_result = s.wb_result;
        if (expect_out) sb_q.push_back(predict(model, s));
        @(posedge clk);
        model = advance(model, s);
        #1;
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("alu_a", alu_a, e.a);
                check("alu_b", alu_b, e.b);
                check("alu_f", {29'd0, alu_f}, {29'd0, e.f});
                check("ex_store_data", ex_store_data, e.st);
                check("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
                check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                check("ex_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                      {28'd0, e.rw, e.mr, e.mw, e.mt});
                check("load_use", {31'd0, load_use}, {31'd0, e.lu});
            end
        end
    end

    initial begin
        stim_t s, add_i, ld_i, dep_i, st_i;
        model = '{default: '0};
        @(posedge clk); #1;

        s = idle(); s.rst = 1;
        cycle(s, 0);
        cycle(s, 0);
        // Reset state seen with idle inputs.
        s = idle();
        cycle(s, 1);

        // ADD r?, r1(5), r2(7), no forwarding.
        add_i = idle(); add_i.valid = 1; add_i.rs = 1; add_i.rs_val = 5; add_i.rt = 2;
        add_i.rt_val = 7; add_i.rd = 9; add_i.aluctrl = 3'b010; add_i.regwrite = 1;
        cycle(add_i, 1);
        cycle(idle(), 1);

        // EX holds rs=3 (val 1); re-presented each cycle while forward sources vary.
        s = idle(); s.valid = 1; s.rs = 3; s.rs_val = 1; s.rt = 8; s.rt_val = 2; s.aluctrl = 3'b110;
        cycle(s, 1);
        s.mem_regwrite = 1; s.mem_rd = 3; s.mem_result = 32'hAA;
        s.wb_regwrite = 1; s.wb_rd = 3; s.wb_result = 32'hBB;
        cycle(s, 1);
        s.mem_rd = 7;
        cycle(s, 1);
        s.mem_rd = 0; s.wb_rd = 0;
        cycle(s, 1);

        // LW r4 followed by a dependent instruction: one bubble, then it loads.
        ld_i = idle(); ld_i.valid = 1; ld_i.rs = 5; ld_i.rs_val = 32'h100; ld_i.rd = 4;
        ld_i.alusrc = 1; ld_i.imm = 8; ld_i.memread = 1; ld_i.memtoreg = 1; ld_i.regwrite = 1;
        cycle(ld_i, 1);
        dep_i = idle(); dep_i.valid = 1; dep_i.rs = 1; dep_i.rs_val = 3; dep_i.rt = 4;
        dep_i.rt_val = 9; dep_i.rd = 10; dep_i.regwrite = 1; dep_i.aluctrl = 3'b010;
        cycle(dep_i, 1);
        cycle(dep_i, 1);
        cycle(idle(), 1);

        // Held instruction keeps a WB value that is only forwarded in the first stall cycle.
        s = idle(); s.valid = 1; s.rs = 2; s.rt = 6; s.rt_val = 32'h1; s.rd = 11; s.regwrite = 1;
        cycle(s, 1);
        s = idle(); s.stall = 1; s.wb_regwrite = 1; s.wb_rd = 6; s.wb_result = 32'h55;
        cycle(s, 1);
        s.wb_regwrite = 0;
        cycle(s, 1);
        cycle(s, 1);
        cycle(idle(), 1);

        // Flush beats stall with a valid SW in EX.
        st_i = idle(); st_i.valid = 1; st_i.rs = 1; st_i.rt = 2; st_i.rt_val = 32'h77;
        st_i.alusrc = 1; st_i.imm = 4; st_i.memwrite = 1;
        cycle(st_i, 1);
        s = idle(); s.flush = 1; s.stall = 1;
        cycle(s, 1);
        cycle(idle(), 1);

        // Immediate on ALU B while rt is forwarded to the store data.
        s = idle(); s.valid = 1; s.rs = 1; s.rt = 12; s.rt_val = 32'h3; s.alusrc = 1;
        s.imm = 32'hFFFF_FFFC; s.memwrite = 1;
        cycle(s, 1);
        s = idle(); s.mem_regwrite = 1; s.mem_rd = 12; s.mem_result = 32'h10;
        cycle(s, 1);

        // Randomized traffic with small register indices so hazards and forwards are frequent.
        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 63) == 0);
            s.stall = ($urandom_range(0, 7) == 0);
            s.flush = ($urandom_range(0, 15) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.rs = 5'($urandom_range(0, 7));
            s.rt = 5'($urandom_range(0, 7));
            s.rd = 5'($urandom_range(0, 7));
            s.rs_val = $urandom; s.rt_val = $urandom; s.imm = $urandom;
            s.alusrc = 1'($urandom_range(0, 1));
            s.aluctrl = 3'($urandom_range(0, 7));
            s.regwrite = 1'($urandom_range(0, 1));
            s.memread = ($urandom_range(0, 2) == 0);
            s.memwrite = 1'($urandom_range(0, 1));
            s.memtoreg = 1'($urandom_range(0, 1));
            s.mem_regwrite = 1'($urandom_range(0, 1));
            s.mem_rd = 5'($urandom_range(0, 7));
            s.mem_result = $urandom;
            s.wb_regwrite = 1'($urandom_range(0, 1));
            s.wb_rd = 5'($urandom_range(0, 7));
            s.wb_result = $urandom;
            cycle(s, 1);
        end

        @(negedge clk); #1;
        check("scoreboard_drained", sb_q.size(), 0);
        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #1_000_000;
        if (!done) begin
            $display("FAIL timeout: run did not complete, %0d/%0d checks passed", n_pass, n_total);
            $fatal(1);
        end
    end

endmodule
